// File: rtl/mem_req_pkg.sv
// Shared types for the memory request pipe: write-type encodings and the
// queued entry record.
package mem_req_pkg;
  localparam int DATA_W     = 32;
  localparam int ADDR_MAX_W = 64;

  localparam logic [1:0] WT_SB    = 2'b00;
  localparam logic [1:0] WT_SH    = 2'b01;
  localparam logic [1:0] WT_UNDEF = 2'b10;
  localparam logic [1:0] WT_SW    = 2'b11;

  // addr is sized for the widest supported address; narrower tops zero-extend
  typedef struct packed {
    logic                  read;
    logic                  write;
    logic [ADDR_MAX_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [3:0]            byte_en;
    logic                  misaligned;
  } req_entry_t;
endpackage

// File: rtl/mem_req_align.sv
// Store alignment: lane enables, lane-replicated data and misalignment flag
// from the write type and the low two address bits.
module mem_req_align
  import mem_req_pkg::*;
(
  input  logic [1:0]        write_type,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] data,
  output logic [3:0]        byte_en,
  output logic [DATA_W-1:0] lane_data,
  output logic              misaligned
);
  always_comb begin
    byte_en    = 4'b0000;
    lane_data  = '0;
    misaligned = 1'b0;
    case (write_type)
      WT_SB: begin
        byte_en   = 4'b0001 << addr_lo;
        lane_data = {4{data[7:0]}};
      end
      WT_SH: begin
        byte_en    = 4'b0011 << {addr_lo[1], 1'b0};
        lane_data  = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      WT_SW: begin
        byte_en    = 4'b1111;
        lane_data  = data;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        // undefined type: no lanes enabled, always flagged
        misaligned = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/mem_req_pipe.sv
// Request queue between a load/store unit and the L1: aligns stores on entry,
// buffers DEPTH entries and presents the head combinationally.
module mem_req_pipe
  import mem_req_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_read,
  input  logic                   in_write,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [1:0]             in_write_type,
  input  logic [DATA_W-1:0]      in_write_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_read,
  output logic                   out_write,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DATA_W-1:0]      out_write_data,
  output logic [3:0]             out_byte_en,
  output logic                   out_misaligned,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_entry_t       mem [DEPTH];
  req_entry_t       new_entry;
  req_entry_t       head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [3:0]       al_byte_en;
  logic [DATA_W-1:0] al_data;
  logic             al_misaligned;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && (in_read || in_write);
  assign pop       = out_valid && out_ready;

  mem_req_align u_align (
    .write_type (in_write_type),
    .addr_lo    (in_addr[1:0]),
    .data       (in_write_data),
    .byte_en    (al_byte_en),
    .lane_data  (al_data),
    .misaligned (al_misaligned)
  );

  // A request with both kind bits set is a write that also carries read=1
  always_comb begin
    new_entry         = '0;
    new_entry.read    = in_read;
    new_entry.write   = in_write;
    new_entry.addr    = ADDR_MAX_W'(in_addr);
    new_entry.byte_en = 4'b1111;
    if (in_write) begin
      new_entry.data       = al_data;
      new_entry.byte_en    = al_byte_en;
      new_entry.misaligned = al_misaligned;
    end
  end

  always_ff @(negedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; outputs are gated by out_valid instead
  always_ff @(negedge sys_clk) begin
    if (push && !flush) mem[wr_ptr] <= new_entry;
  end

  assign head           = mem[rd_ptr];
  assign out_read       = out_valid & head.read;
  assign out_write      = out_valid & head.write;
  assign out_addr       = out_valid ? head.addr[ADDR_W-1:0] : '0;
  assign out_write_data = out_valid ? head.data : '0;
  assign out_byte_en    = out_valid ? head.byte_en : 4'b0000;
  assign out_misaligned = out_valid & head.misaligned;

  generate
    if (ADDR_W < ADDR_MAX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^head.addr[ADDR_MAX_W-1:ADDR_W];
    end
  endgenerate
endmodule
